// File: rtl/vc_ingress_pkg.sv
// Shared types and constants for the VC ingress stage.
package vc_ingress_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam int unsigned word_width = 6;
  localparam int unsigned class_bit  = 5;

endpackage

// File: rtl/vc_ingress_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered status flags.
module sync_fifo #(
  parameter int unsigned data_width    = 6,
  parameter int unsigned address_width = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [data_width-1:0]    data_in,
  input  logic [address_width:0]   threshold,
  output logic [data_width-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [address_width:0]   count
);

  localparam int unsigned depth = 1 << address_width;
  localparam logic [address_width:0] depth_count = (address_width + 1)'(depth);

  logic [data_width-1:0]    mem [0:depth-1];
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic [address_width:0]   count_next;
  logic                     wr_do;
  logic                     rd_do;

  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  assign rd_do = rd_en && !empty;
  assign wr_do = wr_en && (!full || rd_do);

  always_comb begin
    count_next = count;
    case ({wr_do, rd_do})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= data_in;
  end

  // Flags come from the next-state count so they line up with the data they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == depth_count);
      almost_full <= (count_next >= threshold);
    end
  end

endmodule

// File: rtl/vc_ingress.sv
// Ingress stage: main FIFO feeding two virtual-channel FIFOs by class bit, with control FSM.
module vc_ingress
  import vc_ingress_pkg::*;
#(
  parameter int unsigned data_width         = word_width,
  parameter int unsigned main_address_width = 2,
  parameter int unsigned vc_address_width   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic                          push_main,
  input  logic [data_width-1:0]         data_in,
  input  logic [main_address_width:0]   Umbral_main,
  input  logic [vc_address_width-1:0]   Umbral_VC0,
  input  logic [vc_address_width-1:0]   Umbral_VC1,
  input  logic                          pop_VC0_fifo,
  input  logic                          pop_VC1_fifo,
  output logic [data_width-1:0]         data_out_VC0,
  output logic [data_width-1:0]         data_out_VC1,
  output logic                          empty_fifo_VC0,
  output logic                          empty_fifo_VC1,
  output logic                          almost_full_main,
  output logic                          idle_out,
  output logic                          active_out,
  output logic                          error_out
);

  state_t state;
  state_t state_next;

  logic [main_address_width:0] thr_main_q, thr_main_d;
  logic [vc_address_width:0]   thr_vc0_q, thr_vc0_d;
  logic [vc_address_width:0]   thr_vc1_q, thr_vc1_d;

  logic [data_width-1:0]       main_head;
  logic                        main_full, main_empty;
  logic [main_address_width:0] main_count;
  logic                        vc0_full, vc0_af;
  logic                        vc1_full, vc1_af;
  logic [vc_address_width:0]   vc0_count, vc1_count;

  logic running, pops_live, route_vc1, tgt_blocked, route;
  logic push_ok, main_wr, overflow;
  logic pop0_req, pop1_req, pop0, pop1, underflow, error_event, any_data;

  always_comb begin
    thr_main_d = thr_main_q;
    thr_vc0_d  = thr_vc0_q;
    thr_vc1_d  = thr_vc1_q;
    if (state == ST_INIT) begin
      thr_main_d = Umbral_main;
      thr_vc0_d  = {1'b0, Umbral_VC0};
      thr_vc1_d  = {1'b0, Umbral_VC1};
    end
  end

  assign running   = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign pops_live = (state != ST_RESET);

  // Head-of-line blocking: a stalled head holds off both VCs.
  assign route_vc1   = main_head[class_bit];
  assign tgt_blocked = route_vc1 ? (vc1_full || vc1_af) : (vc0_full || vc0_af);
  assign route       = running && !main_empty && !tgt_blocked;

  assign push_ok  = running && push_main;
  assign main_wr  = push_ok && (!main_full || route);
  assign overflow = push_ok && main_full && !route;

  assign pop0_req  = pops_live && pop_VC0_fifo;
  assign pop1_req  = pops_live && pop_VC1_fifo;
  assign pop0      = pop0_req && !empty_fifo_VC0;
  assign pop1      = pop1_req && !empty_fifo_VC1;
  assign underflow = (pop0_req && empty_fifo_VC0) || (pop1_req && empty_fifo_VC1);

  assign error_event = overflow || underflow;
  assign any_data    = (main_count != '0) || (vc0_count != '0) || (vc1_count != '0);

  sync_fifo #(.data_width(data_width), .address_width(main_address_width)) u_main (
    .clk(clk), .reset(reset), .wr_en(main_wr), .rd_en(route),
    .data_in(data_in), .threshold(thr_main_d), .data_out(main_head),
    .full(main_full), .empty(main_empty), .almost_full(almost_full_main), .count(main_count)
  );

  sync_fifo #(.data_width(data_width), .address_width(vc_address_width)) u_vc0 (
    .clk(clk), .reset(reset), .wr_en(route && !route_vc1), .rd_en(pop0),
    .data_in(main_head), .threshold(thr_vc0_d), .data_out(data_out_VC0),
    .full(vc0_full), .empty(empty_fifo_VC0), .almost_full(vc0_af), .count(vc0_count)
  );

  sync_fifo #(.data_width(data_width), .address_width(vc_address_width)) u_vc1 (
    .clk(clk), .reset(reset), .wr_en(route && route_vc1), .rd_en(pop1),
    .data_in(main_head), .threshold(thr_vc1_d), .data_out(data_out_VC1),
    .full(vc1_full), .empty(empty_fifo_VC1), .almost_full(vc1_af), .count(vc1_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:            state_next = ST_INIT;
      ST_INIT:             if (!init) state_next = ST_IDLE;
      ST_IDLE, ST_ACTIVE:  state_next = init ? ST_INIT : (any_data ? ST_ACTIVE : ST_IDLE);
      ST_ERROR:            state_next = ST_ERROR;
      default:             state_next = ST_RESET;
    endcase
    if ((state != ST_RESET) && error_event) state_next = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RESET;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      thr_main_q <= '0;
      thr_vc0_q  <= '0;
      thr_vc1_q  <= '0;
    end else begin
      state      <= state_next;
      idle_out   <= (state_next == ST_IDLE);
      active_out <= (state_next == ST_ACTIVE);
      error_out  <= (state_next == ST_ERROR);
      thr_main_q <= thr_main_d;
      thr_vc0_q  <= thr_vc0_d;
      thr_vc1_q  <= thr_vc1_d;
    end
  end

endmodule
